// File: rtl/fft_pkg.sv
// fft_pkg: shared widths, rounding constants and saturation helper for the FFT datapath
package fft_pkg;
    localparam int DW          = 16;
    localparam int TW          = 9;
    localparam int ADDRW       = 6;
    localparam int ROUND_CONST = 128;
    localparam int FRAC_BITS   = 8;
    localparam int PW          = DW + TW + 2;

    typedef logic signed [DW-1:0] data_t;
    typedef logic signed [PW-1:0] prod_t;
    typedef struct packed {
        data_t re;
        data_t im;
    } cplx_t;

    localparam prod_t SAT_MAX = prod_t'((2 ** (DW - 1)) - 1);
    localparam prod_t SAT_MIN = prod_t'(-(2 ** (DW - 1)));

    function automatic data_t sat_dw(input prod_t y);
        return y > SAT_MAX ? data_t'(SAT_MAX) : y < SAT_MIN ? data_t'(SAT_MIN) : data_t'(y);
    endfunction
endpackage

// File: rtl/twiddle_apply_s3_mult.sv
// cmplx_mult_rnd: complex multiply by (optionally conjugated) twiddle, then round and saturate
module cmplx_mult_rnd
    import fft_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_last,
    input  logic              inv,
    input  data_t             a,
    input  data_t             b,
    input  logic [2*TW-1:0]   w,
    output logic              out_valid,
    output logic              out_last,
    output data_t             out_re,
    output data_t             out_im
);
    logic signed [TW:0] c, d;
    prod_t p_re, p_im, y_re, y_im;
    logic v2, l2;

    // widen before negating so conjugating -256 yields +256 instead of wrapping
    assign c = {w[2*TW-1], w[2*TW-1:TW]};
    assign d = inv ? -{w[TW-1], w[TW-1:0]} : {w[TW-1], w[TW-1:0]};
    assign y_re = (p_re + prod_t'(ROUND_CONST)) >>> FRAC_BITS;
    assign y_im = (p_im + prod_t'(ROUND_CONST)) >>> FRAC_BITS;

    // multiply stage: full-precision products
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2   <= 1'b0;
            l2   <= 1'b0;
            p_re <= '0;
            p_im <= '0;
        end else begin
            v2   <= in_valid;
            l2   <= in_last;
            p_re <= prod_t'(a) * prod_t'(c) - prod_t'(b) * prod_t'(d);
            p_im <= prod_t'(a) * prod_t'(d) + prod_t'(b) * prod_t'(c);
        end
    end

    // output stage: round half up, saturate, hold when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
        end else begin
            out_valid <= v2;
            out_last  <= v2 & l2;
            if (v2) begin
                out_re <= sat_dw(y_re);
                out_im <= sat_dw(y_im);
            end
        end
    end
endmodule

// File: rtl/twiddle_apply_s3.sv
// twiddle_apply_s3: stage-3 twiddle applicator, drives omega ROM and scales each sample
module twiddle_apply_s3
    import fft_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              inv,
    input  logic              din_valid,
    input  data_t             din_re,
    input  data_t             din_im,
    output logic [ADDRW-1:0]  rom_addr,
    input  logic [2*TW-1:0]   rom_data,
    output logic              dout_valid,
    output data_t             dout_re,
    output data_t             dout_im,
    output logic              dout_last
);
    logic [ADDRW-1:0] cnt, idx;
    logic s1_valid, s1_last, s1_inv;
    cplx_t s1_d;

    assign idx = frame_start ? '0 : cnt;
    assign rom_addr = idx;

    // sample index counter; frame_start only takes effect with a valid sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (din_valid)
            cnt <= idx + ADDRW'(1);
    end

    // align sample with the registered ROM word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_inv   <= 1'b0;
            s1_d     <= '0;
        end else begin
            s1_valid <= din_valid;
            s1_last  <= &idx;
            s1_inv   <= inv;
            s1_d     <= '{re: din_re, im: din_im};
        end
    end

    cmplx_mult_rnd u_mult (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s1_valid),
        .in_last   (s1_last),
        .inv       (s1_inv),
        .a         (s1_d.re),
        .b         (s1_d.im),
        .w         (rom_data),
        .out_valid (dout_valid),
        .out_last  (dout_last),
        .out_re    (dout_re),
        .out_im    (dout_im)
    );
endmodule

// File: tb/tb_twiddle_apply_s3.sv
// tb_twiddle_apply_s3: scoreboard bench for the stage-3 twiddle applicator
module tb_twiddle_apply_s3;
    logic clk = 0, rst_n = 0, frame_start = 0, inv = 0, din_valid = 0;
    logic signed [15:0] din_re = 0, din_im = 0;
    logic [5:0] rom_addr;
    logic [17:0] rom_data;
    logic dout_valid, dout_last;
    logic signed [15:0] dout_re, dout_im;
    logic [17:0] rom [64];

    typedef struct {
        logic signed [15:0] re;
        logic signed [15:0] im;
        logic last;
        int cyc;
    } exp_t;
    exp_t q[$];
    exp_t m_e;
    int errors = 0, checks = 0, cyc = 0, tcnt = 0;

    twiddle_apply_s3 dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .inv(inv),
        .din_valid(din_valid), .din_re(din_re), .din_im(din_im),
        .rom_addr(rom_addr), .rom_data(rom_data), .dout_valid(dout_valid),
        .dout_re(dout_re), .dout_im(dout_im), .dout_last(dout_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        rom_data <= rom[rom_addr];
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic signed [15:0] rs(input longint p);
        longint y;
        y = (p + 128) >>> 8;
        if (y > 32767) return 16'sd32767;
        if (y < -32768) return -16'sd32768;
        return 16'(y);
    endfunction

    function automatic logic [17:0] pack(input int re, input int im);
        return {9'(re), 9'(im)};
    endfunction

    always @(negedge clk) begin
        if (rst_n && dout_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got re=%0d im=%0d expected no output", dout_re, dout_im);
            end else begin
                m_e = q.pop_front();
                chk("dout_re", dout_re, m_e.re);
                chk("dout_im", dout_im, m_e.im);
                chk("dout_last", dout_last, m_e.last);
                chk("latency", cyc - m_e.cyc, 3);
            end
        end
    end

    task automatic send(input logic fs, input logic iv, input int a, input int b,
                        input logic hand, input int hre, input int him);
        int idx;
        longint c, d;
        exp_t e;
        @(posedge clk);
        #1;
        idx = fs ? 0 : tcnt;
        frame_start = fs;
        inv = iv;
        din_valid = 1;
        din_re = 16'(a);
        din_im = 16'(b);
        c = $signed(rom[idx][17:9]);
        d = $signed(rom[idx][8:0]);
        if (iv) d = -d;
        e.re = hand ? 16'(hre) : rs(a * c - b * d);
        e.im = hand ? 16'(him) : rs(a * d + b * c);
        e.last = (idx == 63);
        e.cyc = cyc;
        q.push_back(e);
        tcnt = (idx + 1) % 64;
        #1 chk("rom_addr", rom_addr, idx);
    endtask

    task automatic idle(input int n, input logic fs);
        repeat (n) begin
            @(posedge clk);
            #1;
            din_valid = 0;
            frame_start = fs;
        end
        frame_start = 0;
    endtask

    task automatic goto_idx(input int n);
        for (int i = 0; i < n; i++) send(i == 0, 0, 100 * i + 7, -30 * i, 0, 0, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        chk("drain_pending", q.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = pack(i * 7 - 220, 150 - i * 5);
        rom[0]  = pack(255, 0);
        rom[10] = pack(0, -255);
        rom[15] = pack(-235, 97);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", dout_valid, 0);
        chk("rst_re", dout_re, 0);
        chk("rst_im", dout_im, 0);
        chk("rst_last", dout_last, 0);
        chk("rst_addr", rom_addr, 0);
        rst_n = 1;

        send(1, 0, 1000, -500, 1, 996, -498);
        idle(4, 0);
        drain();

        goto_idx(10);
        send(0, 0, 256, 0, 1, 0, -255);
        goto_idx(10);
        send(0, 1, 256, 0, 1, 0, 255);
        goto_idx(15);
        send(0, 0, -32768, -32768, 1, 32767, 17664);
        idle(6, 0);
        drain();
        chk("hold_valid", dout_valid, 0);
        chk("hold_re", dout_re, 32767);
        chk("hold_im", dout_im, 17664);

        for (int i = 0; i < 130; i++)
            send(i == 0, 1'(i % 2), int'($urandom_range(0, 65535)) - 32768,
                 int'($urandom_range(0, 65535)) - 32768, 0, 0, 0);
        idle(5, 0);
        drain();

        goto_idx(5);
        #1;
        rst_n = 0;
        din_valid = 0;
        #1;
        chk("arst_valid", dout_valid, 0);
        chk("arst_re", dout_re, 0);
        chk("arst_im", dout_im, 0);
        chk("arst_last", dout_last, 0);
        q.delete();
        tcnt = 0;
        @(posedge clk);
        #1 rst_n = 1;
        send(0, 0, 1000, -500, 1, 996, -498);
        idle(5, 0);
        drain();

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 2) != 0 || i == 70 || i == 150)
                send(i == 70 || i == 150, 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 65535)) - 32768,
                     int'($urandom_range(0, 65535)) - 32768, 0, 0, 0);
            else
                idle(1, i == 100);
        end
        idle(6, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
